bus_select_encoder: RTL and testbench



---
 rtl/bus_select_encoder_if.sv | 25 ++
 rtl/bus_select_encoder.sv | 106 ++++++++++
 tb/tb_bus_select_encoder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bus_select_encoder_if.sv
// Request/select bundle between the control unit and the bus-select encoder.
// The encoder takes the slave side; the control unit (or bench) drives master.
interface bus_select_encoder_if #(
  parameter int NUM_SRC = 32,
  parameter int SEL_W   = 5,
  parameter int CNT_W   = 8
);
  logic [NUM_SRC-1:0] src_req;
  logic               fault_ack;
  logic [SEL_W-1:0]   bus_sel;
  logic               bus_valid;
  logic               fault;
  logic               conflict;
  logic [CNT_W-1:0]   conflict_count;

  modport master (
    output src_req, fault_ack,
    input  bus_sel, bus_valid, fault, conflict, conflict_count
  );

  modport slave (
    input  src_req, fault_ack,
    output bus_sel, bus_valid, fault, conflict, conflict_count
  );
endinterface

// File: rtl/bus_select_encoder.sv
// Registered one-hot to binary source-select encoder for the 32:1 bus mux,
// with sticky contention fault and a saturating contention counter.
module bus_select_encoder #(
  parameter int NUM_SRC = 32,
  parameter int SEL_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  bus_select_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic               valid_q;
  logic               fault_q;
  logic               conflict_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               req_none;
  logic               req_one;
  logic               req_multi;
  logic [SEL_W-1:0]   sel_d;
  logic [CNT_W-1:0]   cnt_d;

  // Lowest set bit wins so the fault code points at the lowest contender.
  function automatic logic [SEL_W-1:0] enc_lowest(input logic [NUM_SRC-1:0] req);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // x & (x-1) clears the lowest set bit; zero result means at most one bit.
  always_comb begin
    req_none  = (bus.src_req == '0);
    req_one   = !req_none && ((bus.src_req & (bus.src_req - NUM_SRC'(1))) == '0);
    req_multi = !req_none && !req_one;
    sel_d     = enc_lowest(bus.src_req);
    cnt_d     = req_multi ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      conflict_q <= req_multi;
      cnt_q      <= cnt_d;
      case (state_q)
        ST_IDLE, ST_DRIVE: begin
          if (req_one) begin
            state_q <= ST_DRIVE;
            sel_q   <= sel_d;
            valid_q <= 1'b1;
          end else if (req_multi) begin
            state_q <= ST_FAULT;
            sel_q   <= sel_d;
            valid_q <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        ST_FAULT: begin
          // Only a clean bus with an acknowledge releases the fault.
          if (bus.fault_ack && req_none) begin
            state_q <= ST_IDLE;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_sel        = sel_q;
  assign bus.bus_valid      = valid_q;
  assign bus.fault          = fault_q;
  assign bus.conflict       = conflict_q;
  assign bus.conflict_count = cnt_q;

endmodule

// File: tb/tb_bus_select_encoder.sv
// Randomised and directed bench for bus_select_encoder against a
// rule-level reference model of the select/fault/counter behaviour.
module tb_bus_select_encoder;

  localparam int NUM_SRC = 32;
  localparam int SEL_W   = 5;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic clr = 1'b0;

  bus_select_encoder_if #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) bif ();

  bus_select_encoder #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = idle, 1 = driving, 2 = faulted.
  int m_mode  = 0;
  int m_sel   = 0;
  int m_cnt   = 0;
  int m_confl = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest_bit(input logic [31:0] r);
    for (int i = 0; i < 32; i++) if (r[i]) return i;
    return 0;
  endfunction

  task automatic model_edge(input logic [31:0] req, input logic ack, input logic rst_n);
    int n;
    if (!rst_n) begin
      m_mode = 0; m_sel = 0; m_cnt = 0; m_confl = 0;
      return;
    end
    n = $countones(req);
    m_confl = (n > 1) ? 1 : 0;
    if (n > 1 && m_cnt < 255) m_cnt++;
    if (m_mode == 2) begin
      if (ack && n == 0) m_mode = 0;
    end else if (n == 1) begin
      m_mode = 1; m_sel = lowest_bit(req);
    end else if (n > 1) begin
      m_mode = 2; m_sel = lowest_bit(req);
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic step(input logic [31:0] req, input logic ack, input logic rst_n);
    @(negedge clk);
    bif.src_req   = req;
    bif.fault_ack = ack;
    clr           = rst_n;
    @(posedge clk);
    model_edge(req, ack, rst_n);
    #1;
    chk("bus_sel",   32'(bif.bus_sel),        32'(m_sel));
    chk("bus_valid", 32'(bif.bus_valid),      32'(m_mode == 1));
    chk("fault",     32'(bif.fault),          32'(m_mode == 2));
    chk("conflict",  32'(bif.conflict),       32'(m_confl));
    chk("count",     32'(bif.conflict_count), 32'(m_cnt));
  endtask

  function automatic logic [31:0] rand_multi();
    int a, b;
    logic [31:0] r;
    a = $urandom_range(0, 31);
    b = (a + 1 + $urandom_range(0, 30)) % 32;
    r = (32'd1 << a) | (32'd1 << b);
    if ($urandom_range(0, 3) == 0) r = r | $urandom;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] req;
    logic        ack;
    logic        rn;
    int          k;

    bif.src_req   = '0;
    bif.fault_ack = 1'b0;

    // Reset state
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b1, 1'b0);
    chk("rst_sel", 32'(bif.bus_sel), 32'd0);

    // Single requests 0, 17, 31 then idle
    step(32'h1, 1'b0, 1'b1);
    chk("sel0", 32'(bif.bus_sel), 32'd0);
    step(32'd1 << 17, 1'b0, 1'b1);
    chk("sel17", 32'(bif.bus_sel), 32'd17);
    step(32'h8000_0000, 1'b0, 1'b1);
    chk("sel31", 32'(bif.bus_sel), 32'd31);
    chk("valid31", 32'(bif.bus_valid), 32'd1);
    step(32'h0, 1'b0, 1'b0 | 1'b1);
    chk("hold31", 32'(bif.bus_sel), 32'd31);
    chk("idle_valid", 32'(bif.bus_valid), 32'd0);

    // Back-to-back source change
    step(32'd1 << 4, 1'b0, 1'b1);
    step(32'd1 << 9, 1'b0, 1'b1);
    chk("b2b_sel", 32'(bif.bus_sel), 32'd9);
    chk("b2b_valid", 32'(bif.bus_valid), 32'd1);

    // Contention from DRIVE, ack with request ignored, clean ack releases
    step(32'h0000_0140, 1'b0, 1'b1);
    chk("cont_sel", 32'(bif.bus_sel), 32'd6);
    chk("cont_fault", 32'(bif.fault), 32'd1);
    chk("cont_cnt", 32'(bif.conflict_count), 32'd1);
    step(32'h8, 1'b1, 1'b1);
    chk("ack_busy", 32'(bif.fault), 32'd1);
    step(32'h0, 1'b0, 1'b1);
    step(32'h3, 1'b1, 1'b1);
    chk("ack_multi", 32'(bif.fault), 32'd1);
    step(32'h0, 1'b1, 1'b1);
    chk("ack_clean", 32'(bif.fault), 32'd0);
    step(32'h0, 1'b1, 1'b1);

    // Counter saturation
    for (int i = 0; i < 300; i++) step(rand_multi(), 1'($urandom_range(0, 1)), 1'b1);
    chk("sat_cnt", 32'(bif.conflict_count), 32'd255);
    chk("sat_confl", 32'(bif.conflict), 32'd1);
    step(32'h8000_0001, 1'b1, 1'b1);
    chk("sat_hold", 32'(bif.conflict_count), 32'd255);
    chk("alias_sel", 32'(bif.bus_sel), 32'(m_sel));

    // Reset mid-fault with a multi request present
    step(32'h3, 1'b1, 1'b0);
    chk("rst_cnt", 32'(bif.conflict_count), 32'd0);
    step(32'd1 << 12, 1'b0, 1'b1);
    chk("post_rst_sel", 32'(bif.bus_sel), 32'd12);
    chk("post_rst_valid", 32'(bif.bus_valid), 32'd1);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(0, 9);
      if (k < 3)      req = '0;
      else if (k < 7) req = 32'd1 << $urandom_range(0, 31);
      else if (k < 9) req = rand_multi();
      else            req = 32'(bif.src_req);
      ack = ($urandom_range(0, 2) == 0);
      rn  = ($urandom_range(0, 60) != 0);
      step(req, ack, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
